// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage that issues data-memory requests and stalls upstream until ack or timeout
module mem_access #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ex,
  input  logic        memr_ex,
  input  logic        memw_ex,
  input  logic        wrf_ex,
  input  logic        wdc_ex,
  input  logic [31:0] alud_ex,
  input  logic [31:0] wdata_ex,
  input  logic [4:0]  wa_ex,
  output logic        wrf_mem,
  output logic        wdc_mem,
  output logic [31:0] dmemd_mem,
  output logic [31:0] alud_mem,
  output logic [4:0]  wa_mem,
  output logic        stall_mem,
  output logic        err_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] rdq_q, rdq_d;
  logic        to_q, to_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_op, bad, go, tmo;
  assign mem_op   = valid_ex & (memr_ex | memw_ex);
  assign bad      = mem_op & ((alud_ex[1:0] != 2'b00) | (memr_ex & memw_ex));
  assign go       = mem_op & ~bad;
  // this edge would be the MAX_WAIT-th BUSY edge without an ack
  assign tmo      = (32'(wcnt_q) + 32'd1) >= MAX_WAIT;
  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  // state and request registers, cleared asynchronously so a reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      rdq_q   <= 32'd0;
      to_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdq_q   <= rdq_d;
      to_q    <= to_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  // next state: launch on a legal op, finish on ack (which beats timeout), return to IDLE after DONE
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdq_d   = rdq_q;
    to_d    = to_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = BUSY;
        req_d   = 1'b1;
        we_d    = memw_ex;
        addr_d  = alud_ex;
        wdata_d = wdata_ex;
        wcnt_d  = 4'd0;
      end
      BUSY: if (dm_ack) begin
        state_d = DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        rdq_d   = we_q ? rdq_q : dm_rdata;
      end else begin
        wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
        if (tmo) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          to_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        to_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // writeback/stall outputs per state; everything forced low while reset is held
  always_comb begin
    wrf_mem   = 1'b0;
    wdc_mem   = 1'b0;
    alud_mem  = 32'd0;
    wa_mem    = 5'd0;
    dmemd_mem = 32'd0;
    stall_mem = 1'b0;
    err_mem   = 1'b0;
    if (rst) begin
      alud_mem = alud_ex;
      wa_mem   = wa_ex;
      case (state_q)
        IDLE: begin
          wrf_mem   = wrf_ex & valid_ex & ~mem_op;
          wdc_mem   = wdc_ex;
          err_mem   = bad;
          stall_mem = go;
        end
        BUSY: stall_mem = 1'b1;
        DONE: begin
          wrf_mem   = wrf_ex & ~to_q;
          wdc_mem   = wdc_ex;
          err_mem   = to_q;
          dmemd_mem = (memr_ex & ~to_q) ? rdq_q : 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule
